bram_dp_memory: RTL and testbench

Parametrised true dual-port block RAM; successor to the single-port BRAM used in the memory subsystem. Two independent read/write ports (A, B) share one clock. Adds per-byte write enables, selectable read latency (1 or 2), selectable same-port read-during-write mode, defined cross-port collision rules and an optional post-reset clear sweep. Intended for CPU data memory, with port A serving the core and port B serving DMA/debug.

---
 rtl/bram_pkg.sv | 25 ++
 rtl/bram_rd_pipe.sv | 59 +++++
 rtl/bram_dp_memory.sv | 208 ++++++++++++++++++++
 tb/tb_bram_dp_memory.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
//   Shared definitions for the dual-port block RAM:
//     - write-mode encodings for same-port read-during-write
//     - clear/ready FSM state type
//     - byte-lane count helper
// ---------------------------------------------------------------------------
package bram_pkg;

    // Same-port read-during-write behaviour
    localparam int WM_READ_FIRST  = 0;   // read returns the pre-write word
    localparam int WM_WRITE_FIRST = 1;   // read returns the byte-merged word

    // Post-reset sequencing
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } bram_state_e;

    // Number of byte-enable lanes in a word
    function automatic int bram_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// ---------------------------------------------------------------------------
// bram_rd_pipe
//   Per-port read output pipeline. The top module registers the array read
//   on the acceptance edge (stage 1); this block adds the optional second
//   output register and tracks read validity through a valid shift register.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   rd_vld_i    : a read was accepted this cycle
//   rd_data_i   : stage-1 read register (valid one cycle after rd_vld_i)
//   dout_o      : port read data, holds when no read completes
//   valid_o     : one-cycle pulse when dout_o carries a new read
// ---------------------------------------------------------------------------
module bram_rd_pipe #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_vld_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  valid_o
);

    // vld_pipe_q[s] is set when the read accepted s edges ago is live
    logic [READ_LATENCY:1] vld_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_vld_i;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
            end
        end
    end

    assign valid_o = vld_pipe_q[READ_LATENCY];

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q;

        // Load only when stage 1 holds a fresh read so dout holds otherwise
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (vld_pipe_q[1]) begin
                dout_q <= rd_data_i;
            end
        end

        assign dout_o = dout_q;
    end else begin : g_lat1
        assign dout_o = rd_data_i;
    end

endmodule

// File: rtl/bram_dp_memory.sv
// ---------------------------------------------------------------------------
// bram_dp_memory
//   True dual-port block RAM, single clock. Per-byte write enables, read
//   latency 1 or 2, READ_FIRST / WRITE_FIRST same-port behaviour, defined
//   cross-port collisions and an optional post-reset clear sweep.
//   Port A is intended for the core, port B for DMA/debug.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   init_done           : high once port traffic is accepted
//   x_en                : port access request (every accepted access reads)
//   x_we[NB]            : byte write enables, lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   x_addr, x_din       : word address, write data
//   x_dout, x_valid     : read data and its valid pulse
//   (x = a, b)
//
// Collision rules (same address, same cycle)
//   write vs read : reader sees the old word
//   write vs write: per byte, port A wins where both enable it
//   read vs read  : identical data
// ---------------------------------------------------------------------------
module bram_dp_memory
    import bram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    WRITE_MODE     = WM_READ_FIRST,
    parameter int                    CLEAR_ON_RESET = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    output logic                                           init_done,

    input  logic                                           a_en,
    input  logic [bram_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]     a_we,
    input  logic [ADDR_WIDTH-1:0]                          a_addr,
    input  logic [DATA_WIDTH-1:0]                          a_din,
    output logic [DATA_WIDTH-1:0]                          a_dout,
    output logic                                           a_valid,

    input  logic                                           b_en,
    input  logic [bram_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]     b_we,
    input  logic [ADDR_WIDTH-1:0]                          b_addr,
    input  logic [DATA_WIDTH-1:0]                          b_din,
    output logic [DATA_WIDTH-1:0]                          b_dout,
    output logic                                           b_valid
);

    localparam int NB    = bram_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // ---------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_dp_memory: READ_LATENCY must be 1 or 2");
    end

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("bram_dp_memory: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // ---------------------------------------------------------------
    // Storage and control
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    bram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_we;

    logic                  a_acc, b_acc;
    logic [DATA_WIDTH-1:0] a_rd_d, b_rd_d;
    logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;

    // Replace the enabled byte lanes of old_w with din
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [NB-1:0]         we,
        input logic [DATA_WIDTH-1:0] din
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                w[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return w;
    endfunction

    // ---------------------------------------------------------------
    // Clear / ready FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_READY;
                end else begin
                    // Leave on the edge that writes the last word; the
                    // counter wrapping to zero is harmless.
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        init_done = (state_q == ST_READY);
        clr_we    = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    end

    // ---------------------------------------------------------------
    // Array writes
    // ---------------------------------------------------------------
    assign a_acc = a_en && init_done;
    assign b_acc = b_en && init_done;

    // Port B lanes are issued first so that port A's later assignment wins
    // on any byte both ports enable at the same address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_acc && b_we[i]) begin
                    mem_q[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (a_acc && a_we[i]) begin
                    mem_q[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Array reads (stage 1)
    // ---------------------------------------------------------------
    // The array value seen here is always pre-write, so cross-port readers
    // get the old word. WRITE_FIRST only folds in the port's own lanes.
    always_comb begin
        a_rd_d = mem_q[a_addr];
        b_rd_d = mem_q[b_addr];
        if (WRITE_MODE == WM_WRITE_FIRST) begin
            a_rd_d = merge_bytes(a_rd_d, a_we, a_din);
            b_rd_d = merge_bytes(b_rd_d, b_we, b_din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            if (a_acc) a_rd_q <= a_rd_d;
            if (b_acc) b_rd_q <= b_rd_d;
        end
    end

    // ---------------------------------------------------------------
    // Output pipelines
    // ---------------------------------------------------------------
    bram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_a_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_vld_i  (a_acc),
        .rd_data_i (a_rd_q),
        .dout_o    (a_dout),
        .valid_o   (a_valid)
    );

    bram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_b_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_vld_i  (b_acc),
        .rd_data_i (b_rd_q),
        .dout_o    (b_dout),
        .valid_o   (b_valid)
    );

endmodule

// File: tb/tb_bram_dp_memory.sv
// ---------------------------------------------------------------------------
// tb_bram_dp_memory
//   Two instances share stimulus:
//     u0 : LAT=2, READ_FIRST,  clear sweep to 32'hDEAD_BEEF
//     u1 : LAT=1, WRITE_FIRST, no clear sweep (contents tracked per byte)
//   A word/byte-level reference model predicts init_done, valids and douts
//   every cycle; directed sequences add explicit constant checks.
// ---------------------------------------------------------------------------
module tb_bram_dp_memory;

    localparam logic [31:0] IV = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst0, rst1;
    logic            a_en, b_en;
    logic [3:0]      a_we, b_we;
    logic [3:0]      a_addr, b_addr;
    logic [31:0]     a_din, b_din;
    logic [1:0]      init_done, a_valid, b_valid;
    logic [1:0][31:0] a_dout, b_dout;

    bram_dp_memory #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2),
        .WRITE_MODE(0), .CLEAR_ON_RESET(1), .INIT_VALUE(IV)
    ) u0 (
        .clk(clk), .rst(rst0), .init_done(init_done[0]),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[0]), .a_valid(a_valid[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[0]), .b_valid(b_valid[0])
    );

    bram_dp_memory #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
        .WRITE_MODE(1), .CLEAR_ON_RESET(0), .INIT_VALUE(32'h0)
    ) u1 (
        .clk(clk), .rst(rst1), .init_done(init_done[1]),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[1]), .a_valid(a_valid[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[1]), .b_valid(b_valid[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          need [2] = '{16, 1};
    int          lat  [2] = '{2, 1};
    bit          wf   [2] = '{1'b0, 1'b1};
    bit          clr  [2] = '{1'b1, 1'b0};

    logic [31:0] mm [2][16];   // word contents
    logic [31:0] mk [2][16];   // known-bit mask
    int          rel [2];      // edges seen since reset release
    logic        hav [2][2], hbv [2][2];
    logic [31:0] had [2][2], hak [2][2], hbd [2][2], hbk [2][2];
    logic        eav [2], ebv [2], eid [2];
    logic [31:0] ead [2], eak [2], ebd [2], ebk [2];

    function automatic logic [31:0] bmask(input logic [3:0] we);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (we[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic model_reset(input int d);
        rel[d] = 0;
        for (int s = 0; s < 2; s++) begin
            hav[d][s] = 1'b0; hbv[d][s] = 1'b0;
        end
        eav[d] = 1'b0; ebv[d] = 1'b0; eid[d] = 1'b0;
        ead[d] = '0; ebd[d] = '0; eak[d] = '1; ebk[d] = '1;
    endtask

    task automatic model_edge(input int d, input logic rstv);
        logic        rdy, aa, ab;
        logic [31:0] wa, wb, ra, rb, rka, rkb;
        int          k;
        if (rstv) begin
            model_reset(d);
            return;
        end
        rdy = (rel[d] >= need[d]);
        aa  = a_en && rdy;
        ab  = b_en && rdy;
        wa  = bmask(a_we);
        wb  = bmask(b_we);
        ra  = mm[d][a_addr]; rka = mk[d][a_addr];
        rb  = mm[d][b_addr]; rkb = mk[d][b_addr];
        if (wf[d]) begin
            ra = (ra & ~wa) | (a_din & wa); rka = rka | wa;
            rb = (rb & ~wb) | (b_din & wb); rkb = rkb | wb;
        end
        // B first, then A: A owns bytes both ports enable
        if (ab) begin
            mm[d][b_addr] = (mm[d][b_addr] & ~wb) | (b_din & wb);
            mk[d][b_addr] = mk[d][b_addr] | wb;
        end
        if (aa) begin
            mm[d][a_addr] = (mm[d][a_addr] & ~wa) | (a_din & wa);
            mk[d][a_addr] = mk[d][a_addr] | wa;
        end
        if (!rdy && clr[d]) begin
            mm[d][rel[d]] = IV;
            mk[d][rel[d]] = '1;
        end
        if (!rdy) rel[d]++;
        eid[d] = (rel[d] >= need[d]);
        hav[d][1] = hav[d][0]; had[d][1] = had[d][0]; hak[d][1] = hak[d][0];
        hbv[d][1] = hbv[d][0]; hbd[d][1] = hbd[d][0]; hbk[d][1] = hbk[d][0];
        hav[d][0] = aa; had[d][0] = ra; hak[d][0] = rka;
        hbv[d][0] = ab; hbd[d][0] = rb; hbk[d][0] = rkb;
        k = lat[d] - 1;
        eav[d] = hav[d][k];
        ebv[d] = hbv[d][k];
        if (eav[d]) begin ead[d] = had[d][k]; eak[d] = hak[d][k]; end
        if (ebv[d]) begin ebd[d] = hbd[d][k]; ebk[d] = hbk[d][k]; end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d.init_done", d), 32'(init_done[d]), 32'(eid[d]));
            chk($sformatf("u%0d.a_valid", d),   32'(a_valid[d]),   32'(eav[d]));
            chk($sformatf("u%0d.b_valid", d),   32'(b_valid[d]),   32'(ebv[d]));
            chk($sformatf("u%0d.a_dout", d), a_dout[d] & eak[d], ead[d] & eak[d]);
            chk($sformatf("u%0d.b_dout", d), b_dout[d] & ebk[d], ebd[d] & ebk[d]);
        end
    endtask

    // One clock: model sees the inputs the DUTs sample, then compare at +1
    task automatic cyc();
        @(posedge clk);
        model_edge(0, rst0);
        model_edge(1, rst1);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [3:0] we, input logic [31:0] din);
        a_en = 1'b1; a_addr = addr; a_we = we; a_din = din;
    endtask

    task automatic randomize_ports(input int addr_max);
        a_en = 1'($urandom); b_en = 1'($urandom);
        a_we = 4'($urandom); b_we = 4'($urandom);
        a_addr = 4'($urandom_range(0, addr_max));
        b_addr = 4'($urandom_range(0, addr_max));
        a_din = $urandom; b_din = $urandom;
    endtask

    int cnt;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) begin mm[d][i] = '0; mk[d][i] = '0; end
        idle();
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        check_outputs();
        for (int i = 0; i < 3; i++) cyc();

        // ---- clear sweep: init_done after exactly 16 edges, traffic ignored
        rst0 = 1'b0;
        cnt = 0;
        while (init_done[0] !== 1'b1 && cnt < 40) begin
            randomize_ports(15);
            cyc();
            cnt++;
        end
        chk("sweep_len", 32'(cnt), 32'd16);
        idle();
        rst1 = 1'b0;
        cyc();

        // every word reads back as the clear value (u0)
        for (int i = 0; i < 16; i++) begin
            a_en = 1'b1; a_we = '0; a_addr = 4'(i);
            b_en = 1'b1; b_we = '0; b_addr = 4'(15 - i);
            cyc();
        end
        drain(2);
        chk("sweep_word_a", a_dout[0], IV);
        chk("sweep_word_b", b_dout[0], IV);

        // fill every word on both instances
        for (int i = 0; i < 16; i++) begin
            wr_a(4'(i), 4'hF, $urandom);
            cyc();
        end
        drain(2);

        // ---- byte enables
        wr_a(4'd5, 4'b1111, 32'h1122_3344); cyc();
        wr_a(4'd5, 4'b0101, 32'hAAAA_AAAA); cyc();
        wr_a(4'd5, 4'b0000, 32'h0);         cyc();
        drain(2);
        chk("byte_we_u0", a_dout[0], 32'h11AA_33AA);
        chk("byte_we_u1", a_dout[1], 32'h11AA_33AA);

        // ---- same-port read during write
        wr_a(4'd9, 4'hF, 32'h0);           cyc();
        wr_a(4'd9, 4'hF, 32'h5555_5555);   cyc();
        chk("write_first_u1", a_dout[1], 32'h5555_5555);
        idle(); cyc();
        chk("read_first_u0", a_dout[0], 32'h0);
        drain(1);

        // ---- both ports write the same word
        wr_a(4'd7, 4'hF, 32'h0); cyc();
        wr_a(4'd7, 4'b0011, 32'hFFFF_FFFF);
        b_en = 1'b1; b_addr = 4'd7; b_we = 4'b0110; b_din = 32'h0;
        cyc();
        idle();
        wr_a(4'd7, 4'b0000, 32'h0); cyc();
        drain(2);
        chk("ww_collide_u0", a_dout[0], 32'h0000_FFFF);
        chk("ww_collide_u1", a_dout[1], 32'h0000_FFFF);

        // ---- A writes while B reads the same word
        wr_a(4'd3, 4'hF, 32'h1234_5678); cyc();
        wr_a(4'd3, 4'hF, 32'hCAFE_F00D);
        b_en = 1'b1; b_addr = 4'd3; b_we = 4'b0000;
        cyc();
        drain(2);
        chk("wr_collide_u0", b_dout[0], 32'h1234_5678);
        chk("wr_collide_u1", b_dout[1], 32'h1234_5678);
        b_en = 1'b1; b_addr = 4'd3; b_we = 4'b0000; cyc();
        drain(2);
        chk("after_wr_u0", b_dout[0], 32'hCAFE_F00D);
        chk("after_wr_u1", b_dout[1], 32'hCAFE_F00D);

        // ---- random traffic, narrow address range for frequent collisions
        for (int i = 0; i < 400; i++) begin
            randomize_ports((i % 2 == 0) ? 3 : 15);
            cyc();
        end

        // ---- reset with reads in flight
        a_en = 1'b1; a_we = '0; a_addr = 4'd1;
        b_en = 1'b1; b_we = '0; b_addr = 4'd2;
        cyc(); cyc();
        #2;
        rst0 = 1'b1; rst1 = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        chk("rst_a_valid_u0", 32'(a_valid[0]), 32'd0);
        chk("rst_b_valid_u0", 32'(b_valid[0]), 32'd0);
        chk("rst_a_valid_u1", 32'(a_valid[1]), 32'd0);
        chk("rst_a_dout_u0", a_dout[0], 32'h0);
        for (int i = 0; i < 2; i++) begin
            randomize_ports(15);   // ignored while in reset
            cyc();
        end
        idle();
        rst0 = 1'b0;
        for (int i = 0; i < 9; i++) cyc();   // sweep counter reaches 9

        #2;
        rst0 = 1'b1;
        model_reset(0);
        #1;
        chk("mid_sweep_rst_init", 32'(init_done[0]), 32'd0);
        cyc();
        rst0 = 1'b0;
        cnt = 0;
        while (init_done[0] !== 1'b1 && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("resweep_len", 32'(cnt), 32'd16);
        rst1 = 1'b0;
        cyc();

        // contents after reset: cleared on u0, retained on u1
        for (int i = 0; i < 40; i++) begin
            a_en = 1'($urandom); a_we = '0; a_addr = 4'($urandom);
            b_en = 1'($urandom); b_we = '0; b_addr = 4'($urandom);
            cyc();
        end
        a_en = 1'b1; a_we = '0; a_addr = 4'd5; cyc();
        drain(2);
        chk("resweep_word_u0", a_dout[0], IV);
        chk("retained_u1", a_dout[1], mm[1][5]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
